// File: rtl/q2a03_oam_dma.sv
// Sprite DMA engine and CPU/bus arbiter: copies page $XX00-$XXFF to OAMDATA, one bus action per CPU cycle.
// State moves only on G_cycle_stb; the CPU is held off through cpu_ready for 513 or 514 CPU cycles.
module q2a03_oam_dma #(
  parameter logic [15:0] REG_ADDR     = 16'h4014,
  parameter logic [15:0] OAMDATA_ADDR = 16'h2004
) (
  input  logic        G_clock,
  input  logic        G_reset,
  input  logic        G_cycle_stb,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wr_data,
  input  logic        cpu_rdwr,
  output logic        cpu_ready,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wr_data,
  output logic        bus_rdwr,
  input  logic [7:0]  bus_rd_data,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PEND,
    S_HALT,
    S_ALIGN,
    S_READ,
    S_WRITE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic        put;
  logic [7:0]  page;
  logic [7:0]  page_nxt;
  logic [7:0]  idx;
  logic [7:0]  idx_nxt;
  logic [7:0]  data;
  logic [7:0]  data_nxt;
  logic        ready_nxt;
  logic        reg_wr;

  assign reg_wr = !cpu_rdwr && (cpu_addr == REG_ADDR);

  always_ff @(posedge G_clock) begin
    if (G_reset) begin
      state     <= S_IDLE;
      put       <= 1'b0;
      page      <= 8'h00;
      idx       <= 8'h00;
      data      <= 8'h00;
      cpu_ready <= 1'b1;
    end else if (G_cycle_stb) begin
      state     <= state_nxt;
      put       <= ~put;
      page      <= page_nxt;
      idx       <= idx_nxt;
      data      <= data_nxt;
      cpu_ready <= ready_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    page_nxt  = page;
    idx_nxt   = idx;
    data_nxt  = data;
    unique case (state)
      S_IDLE: begin
        if (reg_wr) begin
          page_nxt  = cpu_wr_data;
          state_nxt = S_PEND;
        end
      end
      // The 6502 ignores ready on write cycles, so the halt lands on the first read.
      S_PEND: begin
        if (cpu_rdwr) begin
          state_nxt = S_HALT;
        end else if (reg_wr) begin
          page_nxt = cpu_wr_data;
        end
      end
      // put is this cycle's parity; reads must land on get cycles.
      S_HALT: begin
        state_nxt = put ? S_READ : S_ALIGN;
      end
      S_ALIGN: begin
        state_nxt = S_READ;
      end
      S_READ: begin
        data_nxt  = bus_rd_data;
        state_nxt = S_WRITE;
      end
      S_WRITE: begin
        idx_nxt   = idx + 8'd1;
        state_nxt = (idx == 8'hFF) ? S_IDLE : S_READ;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign ready_nxt  = (state_nxt == S_IDLE) || (state_nxt == S_PEND);
  assign dma_active = (state != S_IDLE) && (state != S_PEND);

  always_comb begin
    bus_addr    = cpu_addr;
    bus_wr_data = cpu_wr_data;
    bus_rdwr    = cpu_rdwr;
    if (state == S_READ) begin
      bus_addr    = {page, idx};
      bus_wr_data = data;
      bus_rdwr    = 1'b1;
    end else if (state == S_WRITE) begin
      bus_addr    = OAMDATA_ADDR;
      bus_wr_data = data;
      bus_rdwr    = 1'b0;
    end
  end

endmodule

// File: tb/tb_q2a03_oam_dma.sv
// Directed bench for q2a03_oam_dma: memory model feeds bus_rd_data, a queue scoreboard
// holds expected read addresses and OAM write bytes per transfer.
module tb_q2a03_oam_dma;

  localparam logic [15:0] REG     = 16'h4014;
  localparam logic [15:0] OAMDATA = 16'h2004;
  localparam logic [15:0] HALT_PC = 16'h0123;

  logic        G_clock = 1'b0;
  logic        G_reset;
  logic        G_cycle_stb;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wr_data;
  logic        cpu_rdwr;
  logic        cpu_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_wr_data;
  logic        bus_rdwr;
  logic [7:0]  bus_rd_data;
  logic        dma_active;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_raddr[$];
  logic [7:0]  exp_wdata[$];
  logic        tb_put;
  int          stall_cnt;
  int          rd_seen;
  int          wr_seen;
  logic        sample_rd;
  logic        sample_wr;
  logic [15:0] last_raddr;
  logic [7:0]  last_wdata;

  q2a03_oam_dma #(.REG_ADDR(16'h4014), .OAMDATA_ADDR(16'h2004)) dut (
    .G_clock     (G_clock),
    .G_reset     (G_reset),
    .G_cycle_stb (G_cycle_stb),
    .cpu_addr    (cpu_addr),
    .cpu_wr_data (cpu_wr_data),
    .cpu_rdwr    (cpu_rdwr),
    .cpu_ready   (cpu_ready),
    .bus_addr    (bus_addr),
    .bus_wr_data (bus_wr_data),
    .bus_rdwr    (bus_rdwr),
    .bus_rd_data (bus_rd_data),
    .dma_active  (dma_active)
  );

  always #5 G_clock = ~G_clock;

  // Page $FF gives byte[i] = i ^ $A5; other pages get a page-dependent twist.
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ 8'hA5 ^ (a[15:8] + 8'h01);
  endfunction

  assign bus_rd_data = mem_byte(bus_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_transfer(input logic [7:0] page);
    for (int i = 0; i < 256; i++) begin
      exp_raddr.push_back({page, 8'(i)});
      exp_wdata.push_back(mem_byte({page, 8'(i)}));
    end
  endtask

  task automatic monitor();
    sample_rd = 1'b0;
    sample_wr = 1'b0;
    if (!cpu_ready) stall_cnt++;
    if (dma_active && bus_rdwr && bus_addr != HALT_PC) begin
      sample_rd  = 1'b1;
      rd_seen++;
      last_raddr = bus_addr;
      check("rd_expected", 32'(exp_raddr.size() != 0), 32'd1);
      if (exp_raddr.size() != 0) check("rd_addr", 32'(bus_addr), 32'(exp_raddr.pop_front()));
    end else if (dma_active && !bus_rdwr) begin
      sample_wr  = 1'b1;
      wr_seen++;
      last_wdata = bus_wr_data;
      check("wr_expected", 32'(exp_wdata.size() != 0), 32'd1);
      check("wr_addr", 32'(bus_addr), 32'(OAMDATA));
      if (exp_wdata.size() != 0) check("wr_data", 32'(bus_wr_data), 32'(exp_wdata.pop_front()));
    end
  endtask

  // One non-strobe clock, then the strobe clock; outputs sampled just before the strobe edge.
  task automatic begin_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    cpu_addr    = a;
    cpu_wr_data = d;
    cpu_rdwr    = rw;
    G_cycle_stb = 1'b0;
    @(posedge G_clock);
    #1;
    G_cycle_stb = 1'b1;
    #2;
    monitor();
  endtask

  task automatic end_cycle();
    @(posedge G_clock);
    #1;
    G_cycle_stb = 1'b0;
    tb_put      = ~tb_put;
  endtask

  task automatic cpu_cycle(input logic [15:0] a, input logic [7:0] d, input logic rw);
    begin_cycle(a, d, rw);
    end_cycle();
  endtask

  task automatic align_to(input logic p);
    if (tb_put != p) cpu_cycle(16'h8000, 8'h00, 1'b1);
  endtask

  task automatic run_transfer(input int gate_rd, input int reset_wr, input logic [7:0] page);
    int cyc;
    bit done;
    cyc     = 0;
    done    = 1'b0;
    rd_seen = 0;
    wr_seen = 0;
    while (!done) begin
      begin_cycle(HALT_PC, 8'h00, 1'b1);
      if (sample_rd && rd_seen == gate_rd + 1) begin
        G_cycle_stb = 1'b0;
        repeat (50) @(posedge G_clock);
        #1;
        check("gate_addr", 32'(bus_addr), 32'({page, 8'(gate_rd)}));
        check("gate_rdwr", 32'(bus_rdwr), 32'd1);
        check("gate_ready", 32'(cpu_ready), 32'd0);
        check("gate_active", 32'(dma_active), 32'd1);
        G_cycle_stb = 1'b1;
        #1;
      end
      if (sample_wr && wr_seen == reset_wr) begin
        G_reset = 1'b1;
        @(posedge G_clock);
        #1;
        G_reset     = 1'b0;
        G_cycle_stb = 1'b0;
        tb_put      = 1'b0;
        done        = 1'b1;
      end else begin
        end_cycle();
        cyc++;
        if (!dma_active) begin
          done = 1'b1;
        end else if (cyc > 600) begin
          check("transfer_timeout", 32'(cyc), 32'd600);
          done = 1'b1;
        end
      end
    end
  endtask

  task automatic trigger(input logic [7:0] page);
    stall_cnt = 0;
    push_transfer(page);
    cpu_cycle(REG, page, 1'b0);
    cpu_cycle(HALT_PC, 8'h00, 1'b1);
  endtask

  task automatic after_checks(input int exp_stall);
    check("stall_len", 32'(stall_cnt), 32'(exp_stall));
    check("queue_left", 32'(exp_raddr.size() + exp_wdata.size()), 32'd0);
    check("done_ready", 32'(cpu_ready), 32'd1);
    check("done_active", 32'(dma_active), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    G_reset     = 1'b1;
    G_cycle_stb = 1'b0;
    cpu_addr    = 16'h1234;
    cpu_wr_data = 8'h56;
    cpu_rdwr    = 1'b0;
    tb_put      = 1'b0;
    stall_cnt   = 0;
    repeat (3) @(posedge G_clock);
    #1;
    G_reset = 1'b0;
    #1;
    check("rst_ready", 32'(cpu_ready), 32'd1);
    check("rst_active", 32'(dma_active), 32'd0);
    check("rst_bus_addr", 32'(bus_addr), 32'h1234);
    check("rst_bus_wdata", 32'(bus_wr_data), 32'h56);
    check("rst_bus_rdwr", 32'(bus_rdwr), 32'd0);

    // HALT on a put cycle, so the next cycle is get: no ALIGN.
    align_to(1'b1);
    trigger(8'h02);
    check("t1_halted", 32'(cpu_ready), 32'd0);
    run_transfer(-1, -1, 8'h02);
    after_checks(513);

    // HALT on a get cycle: one ALIGN cycle.
    align_to(1'b0);
    trigger(8'h02);
    run_transfer(-1, -1, 8'h02);
    after_checks(514);

    // Two extra write cycles after the trigger, the first rewriting the page.
    align_to(1'b1);
    stall_cnt = 0;
    cpu_cycle(REG, 8'h02, 1'b0);
    cpu_cycle(REG, 8'h07, 1'b0);
    push_transfer(8'h07);
    cpu_cycle(16'h0300, 8'hAA, 1'b0);
    check("defer_ready", 32'(cpu_ready), 32'd1);
    check("defer_active", 32'(dma_active), 32'd0);
    check("defer_bus_rdwr", 32'(bus_rdwr), 32'd0);
    cpu_cycle(HALT_PC, 8'h00, 1'b1);
    check("defer_halted", 32'(cpu_ready), 32'd0);
    run_transfer(-1, -1, 8'h07);
    after_checks(513);

    // Top page: address wrap to $FFFF and last byte $FF ^ $A5.
    align_to(1'b0);
    trigger(8'hFF);
    run_transfer(-1, -1, 8'hFF);
    after_checks(514);
    check("wrap_last_raddr", 32'(last_raddr), 32'hFFFF);
    check("wrap_last_wdata", 32'(last_wdata), 32'h5A);
    check("wrap_bus_mirror", 32'(bus_addr), 32'(HALT_PC));

    // Reset at the 100th write, then a fresh full transfer with a strobe gap.
    align_to(1'b1);
    trigger(8'h03);
    run_transfer(-1, 100, 8'h03);
    check("rst_mid_ready", 32'(cpu_ready), 32'd1);
    check("rst_mid_active", 32'(dma_active), 32'd0);
    check("rst_mid_bus_addr", 32'(bus_addr), 32'(HALT_PC));
    check("rst_mid_bus_rdwr", 32'(bus_rdwr), 32'd1);
    check("rst_mid_writes", 32'(wr_seen), 32'd100);
    cpu_addr    = 16'h4014;
    cpu_wr_data = 8'h99;
    cpu_rdwr    = 1'b0;
    #1;
    check("rst_mid_mirror_addr", 32'(bus_addr), 32'h4014);
    check("rst_mid_mirror_wdata", 32'(bus_wr_data), 32'h99);
    check("rst_mid_mirror_rdwr", 32'(bus_rdwr), 32'd0);
    exp_raddr.delete();
    exp_wdata.delete();

    align_to(1'b1);
    trigger(8'h04);
    run_transfer(37, -1, 8'h04);
    after_checks(513);
    check("fresh_reads", 32'(rd_seen), 32'd256);
    check("fresh_writes", 32'(wr_seen), 32'd256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
